// File: rtl/count_sampler.sv
// Samples an upstream counter into a small FIFO while a step checker watches
// that the counter increments by one each cycle and then parks at Limit.
module count_sampler #(
    parameter int Width = 32,
    parameter int Limit = 64,
    parameter int Depth = 4
) (
    input  logic                     Clk_i,
    input  logic                     Reset_i,
    input  logic [Width-1:0]         Data_i,
    input  logic                     Sample_i,
    output logic [Width-1:0]         Data_o,
    output logic                     Valid_o,
    input  logic                     Ready_i,
    output logic [$clog2(Depth):0]   Level_o,
    output logic                     Overflow_o,
    output logic                     StepErr_o,
    output logic                     Done_o
);

    localparam int PtrW = $clog2(Depth);
    localparam logic [Width-1:0] LimitVal = Width'(Limit);
    localparam logic [PtrW:0]    DepthVal = (PtrW + 1)'(Depth);

    typedef enum logic [1:0] {IDLE, TRACK, HOLD, ERR} state_t;

    logic [Width-1:0] r_mem [Depth];
    logic [PtrW-1:0]  r_wr_ptr;
    logic [PtrW-1:0]  r_rd_ptr;
    logic [PtrW:0]    r_level;
    logic             r_overflow;

    state_t           r_state;
    logic [Width-1:0] r_prev;
    logic             r_step_err;
    logic             r_done;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == DepthVal);
    assign w_pop   = !w_empty && Ready_i;
    // A pop on a full FIFO frees the slot the incoming sample needs.
    assign w_push  = Sample_i && (!w_full || w_pop);
    assign w_drop  = Sample_i && w_full && !w_pop;

    // Storage has no reset; the write is still blocked while reset is held.
    always_ff @(posedge Clk_i) begin
        if (w_push && !Reset_i) begin
            r_mem[r_wr_ptr] <= Data_i;
        end
    end

    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PtrW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (PtrW + 1)'(1);
                2'b01:   r_level <= r_level - (PtrW + 1)'(1);
                default: r_level <= r_level;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) begin
            r_state    <= IDLE;
            r_prev     <= '0;
            r_step_err <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_prev <= Data_i;
            case (r_state)
                IDLE: begin
                    r_state <= TRACK;
                end
                TRACK: begin
                    if ((Data_i > LimitVal) || (Data_i != r_prev + Width'(1))) begin
                        r_state    <= ERR;
                        r_step_err <= 1'b1;
                    end else if (Data_i == LimitVal) begin
                        r_state <= HOLD;
                        r_done  <= 1'b1;
                    end
                end
                HOLD: begin
                    if (Data_i != LimitVal) begin
                        r_state    <= ERR;
                        r_step_err <= 1'b1;
                        r_done     <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ERR;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign Valid_o    = !w_empty;
    // Zero while empty so the output is also zero the moment reset lands.
    assign Data_o     = Valid_o ? r_mem[r_rd_ptr] : '0;
    assign Level_o    = r_level;
    assign Overflow_o = r_overflow;
    assign StepErr_o  = r_step_err;
    assign Done_o     = r_done;

endmodule

// File: doc/count_sampler.md
COUNT_SAMPLER -- requirements
Module: count_sampler

Interface
REQ-001 SHALL have parameter Width, default 32, meaning bit width of the sampled counter value.
REQ-002 SHALL have parameter Limit, default 64, meaning terminal value at which the upstream counter holds.
REQ-003 SHALL have parameter Depth, default 4, meaning number of sample FIFO entries (power of two, >=2).
REQ-004 SHALL have port Clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port Reset_i  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port Data_i  input  Width  upstream counter value, valid every cycle.
REQ-007 SHALL have port Sample_i  input  1  request to capture Data_i this cycle.
REQ-008 SHALL have port Data_o  output  Width  FIFO head sample.
REQ-009 SHALL have port Valid_o  output  1  Data_o holds a valid sample.
REQ-010 SHALL have port Ready_i  input  1  downstream accepts Data_o.
REQ-011 SHALL have port Level_o  output  clog2(Depth)+1  FIFO occupancy.
REQ-012 SHALL have port Overflow_o  output  1  sticky: a sample was dropped.
REQ-013 SHALL have port StepErr_o  output  1  sticky: Data_i violated the counting rule.
REQ-014 SHALL have port Done_o  output  1  registered flag: checker in HOLD state.

Function
REQ-015 SHALL push Data_i on a rising edge when Sample_i=1 and FIFO not full (Level_o<Depth).
REQ-016 SHALL pop the head on a rising edge when Valid_o=1 and Ready_i=1.
REQ-017 SHALL drive Valid_o = (Level_o!=0); no same-cycle bypass: a push into an empty FIFO appears on Data_o one cycle later.
REQ-018 SHALL, when full and a pop occurs in the same cycle as Sample_i=1, accept the push; Level_o stays Depth.
REQ-019 SHALL, when full with no pop and Sample_i=1, drop the sample, leave FIFO contents unchanged, set Overflow_o next cycle.
REQ-020 SHALL, on simultaneous push and pop at non-full, non-empty level, keep Level_o unchanged.
REQ-021 SHALL hold Data_o stable while Valid_o=1 and Ready_i=0.
REQ-022 SHALL implement step checker FSM states IDLE, TRACK, HOLD, ERR, with prev = Data_i registered each cycle.
REQ-023 SHALL transition IDLE->TRACK on the first clock after reset release, capturing prev; Data_i is not checked in IDLE.
REQ-024 SHALL in TRACK require Data_i==prev+1 (Width-bit arithmetic); go HOLD when Data_i==Limit; otherwise error.
REQ-025 SHALL in HOLD require Data_i==Limit; otherwise error.
REQ-026 SHALL on any error (including Data_i>Limit in TRACK or HOLD) go ERR, set StepErr_o next cycle; ERR exits only via reset.
REQ-027 SHALL drive Done_o=1 exactly while FSM is in HOLD.
REQ-028 SHALL keep FIFO operation independent of checker state (sampling continues in ERR).
REQ-029 SHALL wrap read/write pointers modulo Depth without data corruption.

Reset
REQ-030 SHALL, while Reset_i=1, immediately force Level_o=0, Valid_o=0, Data_o=0, Overflow_o=0, StepErr_o=0, Done_o=0, FSM=IDLE, independent of Clk_i.
REQ-031 SHALL discard all FIFO contents on reset asserted mid-operation; no pop or push completes on a clock edge while Reset_i=1.
REQ-032 SHALL clear sticky flags only by reset.

Verification
REQ-033 SHALL cover: upstream counts 8,9,...,64 then holds, no Sample_i -> StepErr_o=0; Done_o=1 from cycle after Data_i=64 onward.
REQ-034 SHALL cover: Data_i sequence 8,9,11 -> StepErr_o=1 one cycle after 11 sampled, stays 1 until reset, Done_o=0.
REQ-035 SHALL cover: Ready_i=0, Sample_i=1 for 5 cycles with Data_i=10..14 -> Level_o=4, Overflow_o=1, then Ready_i=1 pops 10,11,12,13 in order.
REQ-036 SHALL cover: full FIFO, Sample_i=1 and Ready_i=1 same cycle with Data_i=20 -> Level_o stays 4, Overflow_o stays 0, 20 is last out.
REQ-037 SHALL cover: Reset_i asserted between clock edges with Level_o=3 -> Level_o=0, Valid_o=0 before next edge; after release, FSM re-enters IDLE and checks restart.
REQ-038 SHALL cover: 10 push/pop pairs at Level_o=1 -> pointer wrap, output order equals input order.
